// File: rtl/scr1_timer_mc.sv
// Multi-channel machine timer: 64-bit mtime with prescaler and NUM_CMP compare channels.
// Latency: dmem response and read data one cycle after the request; IRQ vector one cycle after STATUS.
// Backpressure: none, every request is accepted at once (dmem_req_ack tied high).
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   dmem_*                SCR1 data-memory slave port, byte address bits [6:0] decoded
//   ext_tick              asynchronous external tick, synchronised internally
//   timer_val             current mtime
//   timer_irq             OR of the enabled pending channels
//   timer_irq_vec         per-channel enabled pending flags, for the PLIC

package scr1_memif_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_timer_mc
  import scr1_memif_pkg::*;
#(
  parameter int NUM_CMP   = 2,
  parameter int DIV_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  input  logic                        ext_tick,
  output logic [63:0]                 timer_val,
  output logic                        timer_irq,
  output logic [NUM_CMP-1:0]          timer_irq_vec
);

  localparam logic [2:0] NCMP = 3'(NUM_CMP);

  // ---------------------------------------------------------------- decode
  logic [6:0] off;
  logic [2:0] ch_raw;
  logic       ch_ok;
  logic       mapped;
  logic       acc_err;
  logic       wr_acc;
  logic       rd_acc;
  logic       unused_addr;

  assign off         = dmem_addr[6:0];
  assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:7];

  // Channel windows start at 0x20, 16 bytes each; anything past the last
  // instantiated channel is unmapped.
  assign ch_raw = off[6:4] - 3'd2;
  assign ch_ok  = (off[6:4] >= 3'd2) && (ch_raw < NCMP);

  always_comb begin
    mapped = 1'b0;
    case (off[6:4])
      3'd0:    mapped = 1'b1;      // CONTROL, DIVIDER, MTIMELO, MTIMEHI
      3'd1:    mapped = ~off[3];   // STATUS, IRQ_EN; 0x18/0x1C are holes
      default: mapped = ch_ok;
    endcase
  end

  assign acc_err = (dmem_width != SCR1_MEM_WIDTH_WORD) | (dmem_addr[1:0] != 2'b00) | ~mapped;
  assign wr_acc  = dmem_req & ~acc_err & (dmem_cmd == SCR1_MEM_CMD_WR);
  assign rd_acc  = dmem_req & ~acc_err & (dmem_cmd == SCR1_MEM_CMD_RD);

  logic wr_ctrl, wr_div, wr_mlo, wr_mhi, wr_stat, wr_ien;
  assign wr_ctrl = wr_acc & (off == 7'h00);
  assign wr_div  = wr_acc & (off == 7'h04);
  assign wr_mlo  = wr_acc & (off == 7'h08);
  assign wr_mhi  = wr_acc & (off == 7'h0C);
  assign wr_stat = wr_acc & (off == 7'h10);
  assign wr_ien  = wr_acc & (off == 7'h14);

  logic [NUM_CMP-1:0] wr_cmplo, wr_cmphi, wr_per, wr_chc;
  always_comb begin
    wr_cmplo = '0;
    wr_cmphi = '0;
    wr_per   = '0;
    wr_chc   = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (wr_acc && ch_ok && (ch_raw == 3'(k))) begin
        wr_cmplo[k] = (off[3:2] == 2'd0);
        wr_cmphi[k] = (off[3:2] == 2'd1);
        wr_per[k]   = (off[3:2] == 2'd2);
        wr_chc[k]   = (off[3:2] == 2'd3);
      end
    end
  end

  // ---------------------------------------------------------------- state
  logic                 ctrl_en, ctrl_ext;
  logic [DIV_WIDTH-1:0] divider, cnt;
  logic [63:0]          mtime, mtime_nxt;
  logic [NUM_CMP-1:0]   status, irq_en, hit_d, periodic;
  logic [63:0]          cmp     [NUM_CMP];
  logic [63:0]          cmp_eff [NUM_CMP];
  logic [31:0]          period  [NUM_CMP];
  logic [NUM_CMP-1:0]   hit, rise, reload;

  // ---------------------------------------------------------------- tick generation
  logic ext_s1, ext_s2, ext_d, ext_pulse, cnt_en, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_s1 <= 1'b0;
      ext_s2 <= 1'b0;
      ext_d  <= 1'b0;
    end else begin
      ext_s1 <= ext_tick;
      ext_s2 <= ext_s1;
      ext_d  <= ext_s2;
    end
  end

  assign ext_pulse = ext_s2 & ~ext_d;
  assign cnt_en    = ctrl_en & (ctrl_ext ? ext_pulse : 1'b1);
  assign tick      = cnt_en & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= 1'b1;
      ctrl_ext <= 1'b0;
      divider  <= '0;
      cnt      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en  <= dmem_wdata[0];
        ctrl_ext <= dmem_wdata[1];
      end
      if (wr_div) divider <= dmem_wdata[DIV_WIDTH-1:0];
      // A DIVIDER write restarts the prescaler so the new ratio takes effect at once.
      if (wr_div)      cnt <= dmem_wdata[DIV_WIDTH-1:0];
      else if (tick)   cnt <= divider;
      else if (cnt_en) cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------- mtime
  // Software writes replace one half of the already-incremented value.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr_mlo) mtime_nxt[31:0]  = dmem_wdata;
    if (wr_mhi) mtime_nxt[63:32] = dmem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mtime <= '0;
    else        mtime <= mtime_nxt;
  end

  // ---------------------------------------------------------------- compare channels
  always_comb begin
    hit    = '0;
    rise   = '0;
    reload = '0;
    for (int k = 0; k < NUM_CMP; k++) begin
      // The comparison sees a CMP value being written this cycle.
      cmp_eff[k] = cmp[k];
      if (wr_cmplo[k]) cmp_eff[k][31:0]  = dmem_wdata;
      if (wr_cmphi[k]) cmp_eff[k][63:32] = dmem_wdata;
      hit[k]    = (mtime >= cmp_eff[k]);
      rise[k]   = hit[k] & ~hit_d[k];
      // Any software write to either CMP half cancels the auto-reload.
      reload[k] = rise[k] & periodic[k] & (period[k] != 32'd0) & ~(wr_cmplo[k] | wr_cmphi[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CMP; k++) begin
        cmp[k]    <= '1;
        period[k] <= '0;
      end
      periodic <= '0;
      hit_d    <= '0;
    end else begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (reload[k]) cmp[k] <= cmp[k] + {32'd0, period[k]};
        else           cmp[k] <= cmp_eff[k];
        if (wr_per[k]) period[k]   <= dmem_wdata;
        if (wr_chc[k]) periodic[k] <= dmem_wdata[0];
      end
      hit_d <= hit;
    end
  end

  // ---------------------------------------------------------------- status / irq
  logic [NUM_CMP-1:0] clr_mask;
  assign clr_mask = wr_stat ? dmem_wdata[NUM_CMP-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status        <= '0;
      irq_en        <= '0;
      timer_irq_vec <= '0;
    end else begin
      // Hardware set wins over a same-cycle W1C.
      status        <= (status & ~clr_mask) | rise;
      if (wr_ien) irq_en <= dmem_wdata[NUM_CMP-1:0];
      timer_irq_vec <= status & irq_en;
    end
  end

  assign timer_irq = |timer_irq_vec;
  assign timer_val = mtime;

  // ---------------------------------------------------------------- read path
  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (off[6:4] == 3'd0) begin
      case (off[3:2])
        2'd0:    rd_val = {30'd0, ctrl_ext, ctrl_en};
        2'd1:    rd_val = 32'(divider);
        2'd2:    rd_val = mtime[31:0];
        default: rd_val = mtime[63:32];
      endcase
    end else if (off[6:4] == 3'd1) begin
      rd_val = off[2] ? 32'(irq_en) : 32'(status);
    end else begin
      for (int k = 0; k < NUM_CMP; k++) begin
        if (ch_raw == 3'(k)) begin
          case (off[3:2])
            2'd0:    rd_val = cmp[k][31:0];
            2'd1:    rd_val = cmp[k][63:32];
            2'd2:    rd_val = period[k];
            default: rd_val = {31'd0, periodic[k]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_rdata <= '0;
    end else begin
      if (!dmem_req)    dmem_resp <= SCR1_MEM_RESP_NOTRDY;
      else if (acc_err) dmem_resp <= SCR1_MEM_RESP_RDY_ER;
      else              dmem_resp <= SCR1_MEM_RESP_RDY_OK;
      dmem_rdata <= rd_acc ? rd_val : '0;
    end
  end

  assign dmem_req_ack = 1'b1;

endmodule

// File: tb/tb_scr1_timer_mc.sv
`timescale 1ns/1ps
module tb_scr1_timer_mc;
  import scr1_memif_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 dmem_req = 1'b0;
  type_scr1_mem_cmd_e   dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]          dmem_addr = '0;
  logic [31:0]          dmem_wdata = '0;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 ext_tick = 1'b0;
  logic [63:0]          timer_val;
  logic                 timer_irq;
  logic [1:0]           timer_irq_vec;

  scr1_timer_mc #(.NUM_CMP(2), .DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dmem_req      (dmem_req),
    .dmem_cmd      (dmem_cmd),
    .dmem_width    (dmem_width),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_req_ack  (dmem_req_ack),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .ext_tick      (ext_tick),
    .timer_val     (timer_val),
    .timer_irq     (timer_irq),
    .timer_irq_vec (timer_irq_vec)
  );

  always #5 clk = ~clk;

  int                  n_chk = 0;
  int                  n_fail = 0;
  type_scr1_mem_resp_e r_resp;
  logic [31:0]         r_data;
  logic [63:0]         prev;
  int                  n;
  logic                seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step n cycles; returns #1 after the last rising edge.
  task automatic cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; the request is captured on the next edge.
  task automatic bus(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e w,
                     input logic [31:0] a, input logic [31:0] d);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = w;
    dmem_addr  = a;
    dmem_wdata = d;
    @(posedge clk);
    #1;
    r_resp   = dmem_resp;
    r_data   = dmem_rdata;
    dmem_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, a, d);
    check("wr_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_OK));
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, a, 32'd0);
    check({tag, "_resp"}, 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_OK));
    check(tag, 64'(r_data), 64'(exp));
  endtask

  task automatic wait_val(input logic [63:0] v, input int budget, input string tag);
    int k = 0;
    while (timer_val !== v && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, timer_val, v);
  endtask

  task automatic ext_pulses(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      ext_tick = 1'b1;
      cycles(5);
      ext_tick = 1'b0;
      cycles(5);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset
    cycles(3);
    check("rst_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    check("rst_rdata", 64'(dmem_rdata), 64'd0);
    check("rst_irq", 64'(timer_irq), 64'd0);
    check("rst_irq_vec", 64'(timer_irq_vec), 64'd0);
    check("rst_mtime", timer_val, 64'd0);
    check("req_ack", 64'(dmem_req_ack), 64'd1);
    rst_n = 1'b1;
    cycles(1);
    check("idle_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));

    rd(32'h00, "rst_control", 32'h1);
    rd(32'h04, "rst_divider", 32'h0);
    rd(32'h20, "rst_cmp0lo", 32'hFFFF_FFFF);
    rd(32'h24, "rst_cmp0hi", 32'hFFFF_FFFF);
    rd(32'h38, "rst_period1", 32'h0);
    rd(32'h10, "rst_status", 32'h0);
    rd(32'h14, "rst_irq_en", 32'h0);
    check("rst_irq_after", 64'(timer_irq), 64'd0);

    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h08, 32'd0);
    check("err_byte_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_ER));
    check("err_byte_rdata", 64'(r_data), 64'd0);
    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'd0);
    check("err_ch2_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_ER));
    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h02, 32'd0);
    check("err_misalign_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_ER));
    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h18, 32'd0);
    check("err_hole_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_ER));
    bus(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h00, 32'd0);
    check("err_wr_resp", 64'(r_resp), 64'(SCR1_MEM_RESP_RDY_ER));
    rd(32'h00, "err_wr_no_effect", 32'h1);
    cycles(1);
    check("noreq_resp", 64'(dmem_resp), 64'(SCR1_MEM_RESP_NOTRDY));
    check("noreq_rdata", 64'(dmem_rdata), 64'd0);

    // ---------------- prescaler: DIVIDER=3 -> one tick per 4 clocks
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h04, 32'h3);
    rd(32'h04, "div_readback", 32'h3);
    wr(32'h00, 32'h1);
    n = 0;
    prev = timer_val;
    while (timer_val === prev && n < 20) begin
      cycles(1);
      n++;
    end
    check("div3_first", timer_val, 64'd1);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      prev = timer_val;
      while (timer_val === prev && n < 20) begin
        cycles(1);
        n++;
      end
      check("div3_period", 64'(n), 64'd4);
      check("div3_step", timer_val, prev + 64'd1);
    end
    // Three cycles after a tick edge, the next captured write lands on a tick.
    cycles(3);
    wr(32'h08, 32'h10);
    check("mlo_wr_on_tick", timer_val, 64'h10);
    wr(32'h00, 32'h0);
    cycles(2);
    rd(32'h08, "mlo_read", 32'h10);
    rd(32'h0C, "mhi_read", 32'h0);

    // ---------------- CH0 one-shot at 100
    wr(32'h04, 32'h0);
    wr(32'h08, 32'd90);
    wr(32'h20, 32'd100);
    wr(32'h24, 32'h0);
    wr(32'h14, 32'h1);
    wr(32'h00, 32'h1);
    wait_val(64'd100, 50, "ch0_reach100");
    check("ch0_irq_t0", 64'(timer_irq), 64'd0);
    cycles(1);
    check("ch0_irq_t1", 64'(timer_irq), 64'd0);
    cycles(1);
    check("ch0_irq_t2", 64'(timer_irq), 64'd1);
    check("ch0_irq_vec", 64'(timer_irq_vec), 64'h1);
    rd(32'h10, "ch0_status", 32'h1);
    wr(32'h10, 32'h1);
    cycles(1);
    check("ch0_irq_cleared", 64'(timer_irq), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      seen = seen | timer_irq;
    end
    check("ch0_irq_stays_low", 64'(seen), 64'd0);
    rd(32'h10, "ch0_status_cleared", 32'h0);
    wr(32'h00, 32'h0);

    // ---------------- CH1 periodic: 50, 70, 90
    wr(32'h20, 32'hFFFF_FFFF);
    wr(32'h24, 32'hFFFF_FFFF);
    wr(32'h14, 32'h2);
    wr(32'h08, 32'd40);
    wr(32'h30, 32'd50);
    wr(32'h34, 32'h0);
    wr(32'h38, 32'd20);
    wr(32'h3C, 32'h1);
    rd(32'h3C, "ch1_chctrl", 32'h1);
    wr(32'h00, 32'h1);
    for (int t = 50; t <= 90; t += 20) begin
      wait_val(64'(t), 100, "ch1_reach");
      check("ch1_vec_before", 64'(timer_irq_vec), 64'h0);
      cycles(2);
      check("ch1_vec_set", 64'(timer_irq_vec), 64'h2);
      check("ch1_irq_set", 64'(timer_irq), 64'd1);
      rd(32'h30, "ch1_cmplo_reload", 32'(t + 20));
      wr(32'h10, 32'h2);
    end

    // ---------------- CH1 periodic reload across 2^64
    wr(32'h00, 32'h0);
    wr(32'h30, 32'hFFFF_FFF6);
    wr(32'h34, 32'hFFFF_FFFF);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h08, 32'hFFFF_FFF0);
    wr(32'h00, 32'h1);
    wait_val(64'hFFFF_FFFF_FFFF_FFF6, 30, "wrap_reach");
    wr(32'h00, 32'h0);
    check("wrap_frozen_mtime", timer_val, 64'hFFFF_FFFF_FFFF_FFF7);
    rd(32'h30, "wrap_cmplo", 32'd10);
    rd(32'h34, "wrap_cmphi", 32'd0);
    check("wrap_still_frozen", timer_val, 64'hFFFF_FFFF_FFFF_FFF7);

    // ---------------- external tick source
    wr(32'h00, 32'h2);
    wr(32'h04, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h3);
    cycles(10);
    check("ext_idle", timer_val, 64'd0);
    ext_pulses(5);
    cycles(5);
    check("ext_5_pulses", timer_val, 64'd5);
    wr(32'h00, 32'h2);
    ext_pulses(2);
    cycles(5);
    check("ext_disabled", timer_val, 64'd5);

    // ---------------- same-cycle hit and W1C of STATUS_0
    wr(32'h10, 32'h3);
    wr(32'h00, 32'h0);
    wr(32'h30, 32'hFFFF_FFFF);
    wr(32'h34, 32'hFFFF_FFFF);
    wr(32'h08, 32'h0);
    wr(32'h20, 32'd20);
    wr(32'h24, 32'h0);
    wr(32'h14, 32'h1);
    wr(32'h00, 32'h1);
    wait_val(64'd20, 50, "race_w1c_reach");
    wr(32'h10, 32'h1);
    rd(32'h10, "race_w1c_status", 32'h1);
    check("race_w1c_irq", 64'(timer_irq), 64'd1);
    wr(32'h10, 32'h1);
    cycles(5);
    check("race_w1c_irq_low", 64'(timer_irq), 64'd0);
    rd(32'h10, "race_w1c_no_reset", 32'h0);
    wr(32'h00, 32'h0);

    // ---------------- same-cycle auto-reload and CMPLO write
    wr(32'h08, 32'd30);
    wr(32'h30, 32'd40);
    wr(32'h34, 32'h0);
    wr(32'h38, 32'd20);
    wr(32'h3C, 32'h1);
    wr(32'h00, 32'h1);
    wait_val(64'd40, 50, "race_reload_reach");
    wr(32'h30, 32'd5);
    wr(32'h00, 32'h0);
    rd(32'h30, "race_reload_cmplo", 32'd5);
    rd(32'h34, "race_reload_cmphi", 32'd0);
    bus(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'd0);
    check("race_reload_status1", 64'(r_data[1]), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
